// File: rtl/image_loader.sv
// image_loader: stores a valid/ready pixel stream row-major into image memory via a write/ack port.
module image_loader #(
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              enable,
   input  logic              clear,
   input  logic [DATA_W-1:0] data_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic              mem_ack,
   output logic [3:0]        col,
   output logic [3:0]        row,
   output logic              at_end
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
   state_t state;
   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic col_end;
   assign col_end  = col_q == COL_LAST;
   // nrst term keeps in_ready at its reset value while reset is held
   assign in_ready = nrst & (state == IDLE) & enable & ~at_end;
   assign col      = 4'(col_q);
   assign row      = 4'(row_q);
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         state     <= IDLE;
         col_q     <= '0;
         row_q     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         at_end    <= 1'b0;
      end else if (clear) begin
         state    <= IDLE;
         col_q    <= '0;
         row_q    <= '0;
         mem_addr <= '0;
         mem_we   <= 1'b0;
         at_end   <= 1'b0;
      end else
         case (state)
            IDLE:
               if (in_valid && in_ready) begin
                  mem_wdata <= data_in;
                  mem_we    <= 1'b1;
                  state     <= WRITE;
               end
            WRITE:
               if (mem_ack) begin
                  mem_we <= 1'b0;
                  if (col_end && row_q == ROW_LAST) begin
                     state  <= DONE;
                     at_end <= 1'b1;
                  end else begin
                     state    <= IDLE;
                     mem_addr <= mem_addr + ADDR_W'(1);
                     col_q    <= col_end ? '0 : col_q + CW'(1);
                     row_q    <= col_end ? row_q + RW'(1) : row_q;
                  end
               end
            DONE: state <= DONE;
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_image_loader.sv
// tb_image_loader: table-driven frame load of a 4x2 image plus clear and async reset sequences.
module tb_image_loader;
   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        enable = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] data_in = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic        mem_ack = 1'b0;
   logic [3:0]  col;
   logic [3:0]  row;
   logic        at_end;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        e, v;
      logic [15:0] d;
      logic        a, rdy, we;
      logic [2:0]  addr;
      logic [15:0] wd;
      logic [3:0]  c, r;
      logic        fin;
   } vec_t;
   vec_t tv[$];

   image_loader #(.IMG_W(4), .IMG_H(2), .DATA_W(16), .ADDR_W(3)) dut (
      .clk(clk), .nrst(nrst), .enable(enable), .clear(clear), .data_in(data_in),
      .in_valid(in_valid), .in_ready(in_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_ack(mem_ack), .col(col), .row(row), .at_end(at_end)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input int i, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h", n, i, act, exp);
      end
   endtask

   task automatic add(input logic e, v, input logic [15:0] d, input logic a, rdy, we,
                      input logic [2:0] addr, input logic [15:0] wd, input logic [3:0] c, r,
                      input logic fin);
      vec_t t;
      t.e = e; t.v = v; t.d = d; t.a = a; t.rdy = rdy; t.we = we;
      t.addr = addr; t.wd = wd; t.c = c; t.r = r; t.fin = fin;
      tv.push_back(t);
   endtask

   task automatic step(input logic e, clr, v, input logic [15:0] d, input logic a);
      enable = e; clear = clr; in_valid = v; data_in = d; mem_ack = a;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string n, input logic rdy, we, input logic [2:0] addr,
                          input logic [15:0] wd, input logic [3:0] c, r, input logic fin);
      chk({n, ".rdy"}, 0, 16'(in_ready), 16'(rdy));
      chk({n, ".we"}, 0, 16'(mem_we), 16'(we));
      chk({n, ".addr"}, 0, 16'(mem_addr), 16'(addr));
      chk({n, ".wdata"}, 0, mem_wdata, wd);
      chk({n, ".col"}, 0, 16'(col), 16'(c));
      chk({n, ".row"}, 0, 16'(row), 16'(r));
      chk({n, ".end"}, 0, 16'(at_end), 16'(fin));
   endtask

   initial begin
      //   e  v  data      a  rdy we addr wdata     col row end
      add(1, 1, 16'h1000, 0, 1, 0, 0, 16'h0000, 0, 0, 0);
      add(1, 0, 16'h0000, 1, 0, 1, 0, 16'h1000, 0, 0, 0);
      add(1, 1, 16'h1001, 0, 1, 0, 1, 16'h1000, 1, 0, 0);
      add(1, 0, 16'h0000, 1, 0, 1, 1, 16'h1001, 1, 0, 0);
      add(1, 1, 16'h1002, 1, 1, 0, 2, 16'h1001, 2, 0, 0);
      add(1, 1, 16'hDEAD, 0, 0, 1, 2, 16'h1002, 2, 0, 0);
      add(1, 1, 16'hDEAD, 0, 0, 1, 2, 16'h1002, 2, 0, 0);
      add(1, 1, 16'hDEAD, 0, 0, 1, 2, 16'h1002, 2, 0, 0);
      add(1, 0, 16'h0000, 1, 0, 1, 2, 16'h1002, 2, 0, 0);
      add(1, 1, 16'h1003, 0, 1, 0, 3, 16'h1002, 3, 0, 0);
      add(1, 0, 16'h0000, 1, 0, 1, 3, 16'h1003, 3, 0, 0);
      add(1, 1, 16'h1004, 0, 1, 0, 4, 16'h1003, 0, 1, 0);
      add(1, 0, 16'h0000, 1, 0, 1, 4, 16'h1004, 0, 1, 0);
      add(1, 1, 16'h1005, 0, 1, 0, 5, 16'h1004, 1, 1, 0);
      add(0, 0, 16'h0000, 0, 0, 1, 5, 16'h1005, 1, 1, 0);
      add(0, 0, 16'h0000, 1, 0, 1, 5, 16'h1005, 1, 1, 0);
      add(0, 1, 16'h1006, 0, 0, 0, 6, 16'h1005, 2, 1, 0);
      add(0, 1, 16'h1006, 0, 0, 0, 6, 16'h1005, 2, 1, 0);
      add(1, 1, 16'h1006, 0, 1, 0, 6, 16'h1005, 2, 1, 0);
      add(1, 0, 16'h0000, 1, 0, 1, 6, 16'h1006, 2, 1, 0);
      add(1, 1, 16'h1007, 0, 1, 0, 7, 16'h1006, 3, 1, 0);
      add(1, 0, 16'h0000, 1, 0, 1, 7, 16'h1007, 3, 1, 0);
      add(1, 1, 16'hBEEF, 1, 0, 0, 7, 16'h1007, 3, 1, 1);
      add(1, 1, 16'hBEEF, 1, 0, 0, 7, 16'h1007, 3, 1, 1);

      #3;
      chk_all("reset", 0, 0, 0, 16'h0000, 0, 0, 0);
      @(negedge clk);
      nrst = 1'b1;
      @(posedge clk);
      #1;

      foreach (tv[i]) begin
         enable = tv[i].e; clear = 1'b0; in_valid = tv[i].v; data_in = tv[i].d; mem_ack = tv[i].a;
         #2;
         chk("rdy", i, 16'(in_ready), 16'(tv[i].rdy));
         chk("we", i, 16'(mem_we), 16'(tv[i].we));
         chk("addr", i, 16'(mem_addr), 16'(tv[i].addr));
         chk("wdata", i, mem_wdata, tv[i].wd);
         chk("col", i, 16'(col), 16'(tv[i].c));
         chk("row", i, 16'(row), 16'(tv[i].r));
         chk("end", i, 16'(at_end), 16'(tv[i].fin));
         @(posedge clk);
         #1;
      end

      step(1, 1, 1, 16'hBEEF, 0);
      chk_all("clr_done", 1, 0, 0, 16'h1007, 0, 0, 0);
      step(1, 0, 1, 16'h2000, 0);
      chk_all("after_clr_wr", 0, 1, 0, 16'h2000, 0, 0, 0);
      step(1, 0, 0, 16'h0000, 1);
      chk_all("after_clr_ack", 1, 0, 1, 16'h2000, 1, 0, 0);
      step(1, 0, 1, 16'h2001, 0);
      chk_all("pre_clr_wr", 0, 1, 1, 16'h2001, 1, 0, 0);
      step(1, 1, 0, 16'h0000, 0);
      chk_all("clr_write", 1, 0, 0, 16'h2001, 0, 0, 0);
      step(1, 1, 1, 16'h3333, 0);
      chk("clr_hs.we", 0, 16'(mem_we), 16'h0);
      chk("clr_hs.addr", 0, 16'(mem_addr), 16'h0);
      step(1, 0, 1, 16'h2002, 0);
      chk_all("clr_hs_next", 0, 1, 0, 16'h2002, 0, 0, 0);
      step(1, 0, 0, 16'h0000, 1);
      step(1, 0, 1, 16'h2003, 0);
      chk_all("pre_rst", 0, 1, 1, 16'h2003, 1, 0, 0);

      #2;
      nrst = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 0, 16'h0000, 0, 0, 0);
      @(negedge clk);
      nrst = 1'b1;
      enable = 1'b1; in_valid = 1'b0; mem_ack = 1'b0;
      @(posedge clk);
      #1;
      chk_all("post_rst", 1, 0, 0, 16'h0000, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/image_loader.md
Name: image_loader

Overview:
- Write-side counterpart to the image readout controller.
- Accepts a stream of 16-bit pixel words over a valid/ready handshake and stores them in row-major order into the image memory through a single-port write interface with an acknowledge.
- Tracks column and row position, flags the end of frame, and supports a synchronous clear for reloading.

Parameters:
- IMG_W, 8, pixels per row (≥2)
- IMG_H, 8, rows per frame (≥2)
- DATA_W, 16, pixel word width
- ADDR_W, 6, memory address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H

Ports:
- clk  input  1  system clock, all state on rising edge
- nrst  input  1  asynchronous active-low reset
- enable  input  1  loader may accept pixels while high
- clear  input  1  synchronous restart to address 0, IDLE, at_end cleared
- data_in  input  DATA_W  incoming pixel word
- in_valid  input  1  data_in is valid
- in_ready  output  1  loader can accept data_in this cycle
- mem_addr  output  ADDR_W  write address
- mem_wdata  output  DATA_W  write data
- mem_we  output  1  write request
- mem_ack  input  1  memory accepted the write (may be same cycle as mem_we)
- col  output  4  current column index (low bits, for LED debug)
- row  output  4  current row index (low bits, for LED debug)
- at_end  output  1  full frame stored

Behaviour:
- One clock; reset is asynchronous and active-low. Clock port is clk, reset port is nrst.
- Reset values: state=IDLE, in_ready=0, mem_addr=0, mem_wdata=0, mem_we=0, col=0, row=0, at_end=0.
- States:
  - IDLE: in_ready = enable & ~at_end. When in_valid & in_ready, capture data_in into mem_wdata and go to WRITE.
  - WRITE: mem_we=1, mem_addr = row*IMG_W + col, held stable until mem_ack; in_ready=0.
    - On mem_ack: deassert mem_we next cycle and advance col/row.
    - If the written pixel was the last (col=IMG_W-1, row=IMG_H-1): go to DONE, else IDLE.
  - DONE: at_end=1, in_ready=0, mem_we=0; stays until clear or reset.
- Address generation:
  - mem_addr is an incrementing counter kept equal to row*IMG_W + col; no multiplier.
  - col wraps IMG_W-1 -> 0 and increments row; row saturates at IMG_H-1 in DONE; mem_addr never exceeds IMG_W*IMG_H-1.
- Throughput: one pixel per 2 cycles minimum (accept cycle + write cycle with immediate ack). Latency from handshake to mem_we = 1 cycle.
- mem_ack outside WRITE is ignored.
- enable low:
  - In IDLE, blocks acceptance.
  - In WRITE, the outstanding write still completes; no write is dropped.
- clear:
  - Highest priority after reset. Any state -> IDLE next cycle; counters and at_end zeroed; mem_we=0 next cycle (an in-flight write is abandoned).
  - A handshake coinciding with clear is discarded.
- col/row outputs are the zero-extended or truncated low 4 bits of the counters.
- No combinational path from in_valid to in_ready; in_ready depends only on state, enable and at_end.

Test Plan:
- Reset then enable=1 with IMG_W=4, IMG_H=2 (ADDR_W=3); stream 8 words 0x1000..0x1007 with mem_ack tied high -> writes at addresses 0..7 with matching data, one per 2 cycles; at_end rises after the 8th ack; in_ready stays 0 afterward.
- mem_ack delayed 3 cycles on pixel 2 -> mem_we/mem_addr=2/mem_wdata held 3 cycles; in_ready=0 throughout; no pixel lost or duplicated.
- Pixel 3 stored (col=3,row=0) -> next write address 4 with col=0, row=1 (wrap check).
- enable dropped during WRITE of pixel 5 -> that write completes; no further acceptance until enable returns; pixel 6 goes to address 6.
- clear asserted in DONE, and separately mid-WRITE -> IDLE next cycle, at_end=0, mem_addr=0, mem_we=0; subsequent pixel is written to address 0.
- nrst pulsed low asynchronously mid-frame (between clock edges) -> all outputs go to reset values immediately, without waiting for a clock edge.
